syn_filt_param: RTL and testbench
=================================

Name: syn_filt_param

Overview:
- Parametrised, self-contained successor to the G.729 synthesis filter.
- Computes y[n] = round(L_shl(a0*x[n] - sum_{i=1..ORDER} a[i]*y[n-i], SHIFT)) over LEN samples.
- Uses internal bit-exact saturating basic-op arithmetic instead of the shared L_add/L_mult/L_msu/L_shl units.
- Adds an explicit update port, a sticky overflow flag, and base+offset addressing so ORDER/LEN are not tied to 64-word pages. Sits on the shared 11-bit scratch memory bus.

Parameters:
ORDER, 10, filter order M (1..31)
LEN, 40, subframe length L (1..63)
SHIFT, 3, left shift applied to the accumulator before rounding (0..15)
TEMP_BASE, SYN_FILT_TEMP, base address of the ORDER+LEN word scratch area
AW, 11, memory address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  1-cycle pulse; begins filtering when idle
update  in  1  sampled at start; 1 = write last ORDER outputs back to filter memory
xAddr  in  AW  base of x[0..LEN-1]
aAddr  in  AW  base of a[0..ORDER]
yAddr  in  AW  base of y[0..LEN-1] output
fMemAddr  in  AW  base of filter memory mem[0..ORDER-1]
memIn  in  32  read data; valid the cycle after memReadAddr
memReadAddr  out  AW  read address
memWriteAddr  out  AW  write address
memWriteEn  out  1  write strobe
memOut  out  32  write data, 16-bit result sign-extended
done  out  1  1-cycle completion pulse
overflow  out  1  sticky saturation flag, valid from done until next start
busy  out  1  high from the cycle after start until done

Behaviour:
- Reset (asynchronous, any state, including mid-operation): state=IDLE; all counters, accumulators and outputs = 0. No write is issued in the reset cycle or the cycle after it.
- Addresses are base + offset using a full AW-bit add with modulo-2^AW wrap; no concatenation.
- Only memIn[15:0] is used, as signed Q15.
- Arithmetic is bit-exact to ITU basic ops:
  - L_mult(a,b) = sat32(2*a*b).
  - L_msu(s,a,b) = sat32(s - L_mult(a,b)).
  - L_shl saturates.
  - round = sat32(s + 0x8000) >> 16.
  - Any saturation event sets overflow. overflow is cleared at an accepted start.
- start is accepted only in IDLE. Starts while busy are ignored and do not restart the operation.
- update is latched at an accepted start.
- States:
  - IDLE: wait for start.
  - LOADM: for k=0..ORDER-1, read fMem+k, then write TEMP_BASE+k (2 cycles/word).
  - RDX: read x[n].
  - RDA0: read a0.
  - MAC0: acc = L_mult(x[n], a0).
  - RDAI: read a[i].
  - RDY: read TEMP_BASE+ORDER+n-i.
  - MSU: acc = L_msu(acc, a[i], y). Loop RDAI/RDY/MSU for i=1..ORDER.
  - SHR: acc = L_shl(acc, SHIFT). Single cycle.
  - WRT: write round(acc) to TEMP_BASE+ORDER+n; n++. If n<LEN go to RDX, else go to COPY.
  - COPY: for n=0..LEN-1, read TEMP_BASE+ORDER+n, then write yAddr+n.
  - UPD (only if update latched=1): for k=0..ORDER-1, read yAddr+LEN-ORDER+k, then write fMem+k.
  - FIN: done=1, go to IDLE.
- When LEN < ORDER, UPD reads scratch TEMP_BASE+LEN+k instead of y, so filter-memory history stays correct.
- Cycle count from start to done is exactly 2*ORDER + LEN*(3*ORDER+5) + 2*LEN + update*2*ORDER + 2.
- Outputs are driven from registered state and counters. Write data, address and enable change together.
- At most one of read/write is meaningful per cycle. memWriteEn is never asserted in IDLE.

Decomposition:
- Shared package (paramList.v) holds:
  - SYN_FILT_TEMP.
  - MAX_32 / MIN_32 / MAX_16 / MIN_16 saturation constants.
  - The state encodings as localparams.
- One sub-module, basic_op_sat: combinational L_mult, L_msu, L_shl and round with an overflow output. It is reusable by other filters.

Test Plan:
- a=[4096,0...0], mem=0, x=[1000,-2000,32767,...], update=0 -> y==x exactly; overflow=0; fMem unchanged; cycle count matches the formula.
- a=[4096,-2048,0..], mem=0, x=[1000,0,0,0,0] -> y=[1000,500,250,125,63]; with update=1, fMem[0..9]=y[30..39].
- a0=32767, x[0]=32767 -> y[0]=32767, overflow=1 at done; the next start with benign data clears overflow to 0.
- Nonzero mem=[100,...], ORDER=10 -> output matches the ITU C Syn_filt golden vectors; rerun with ORDER=16, LEN=20, TEMP_BASE near 2^AW to check address wrap.
- start pulsed while busy -> ignored; a single done pulse at the nominal cycle.
- reset asserted mid-MAC -> all outputs 0 immediately; next start completes with correct y.

Source files
------------

// File: rtl/syn_filt_param_pkg.sv
// Shared definitions for the parametrised synthesis filter: scratch base,
// ITU saturation limits, FSM state encoding and a sign-extension helper.
package syn_filt_param_pkg;

    // Default base of the ORDER+LEN word scratch area on the 11-bit bus
    localparam int SYN_FILT_TEMP = 1792;

    localparam logic signed [31:0] MAX_32 = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] MIN_32 = 32'sh8000_0000;
    localparam logic signed [15:0] MAX_16 = 16'sh7FFF;
    localparam logic signed [15:0] MIN_16 = 16'sh8000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOADM,
        S_RDX,
        S_RDA0,
        S_MAC0,
        S_RDAI,
        S_RDY,
        S_MSU,
        S_SHR,
        S_WRT,
        S_COPY,
        S_UPD,
        S_FIN
    } state_t;

    // Results go onto the 32-bit bus sign-extended from Q15
    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/basic_op_sat.sv
// Combinational bit-exact ITU basic ops: L_mult, L_msu, L_shl (fixed shift)
// and round, each with its own saturation flag.
module basic_op_sat
    import syn_filt_param_pkg::*;
#(
    parameter int SHIFT = 3
) (
    input  logic signed [31:0] i_acc,
    input  logic signed [15:0] i_a,
    input  logic signed [15:0] i_b,
    output logic signed [31:0] o_mult,
    output logic               o_mult_ovf,
    output logic signed [31:0] o_msu,
    output logic               o_msu_ovf,
    output logic signed [31:0] o_shl,
    output logic               o_shl_ovf,
    output logic signed [15:0] o_round,
    output logic               o_round_ovf
);

    logic signed [31:0] w_prod;
    logic signed [32:0] w_diff;
    logic signed [47:0] w_shl_wide;
    logic signed [16:0] w_rsum_hi;
    logic               w_diff_sat;

    // Saturating arithmetic; only -32768*-32768 can overflow the doubled product
    always_comb begin
        w_prod      = 32'(i_a) * 32'(i_b);
        o_mult_ovf  = (w_prod == 32'sh4000_0000);
        o_mult      = o_mult_ovf ? MAX_32 : (w_prod <<< 1);

        w_diff      = 33'(i_acc) - 33'(o_mult);
        w_diff_sat  = (w_diff[32] != w_diff[31]);
        o_msu_ovf   = o_mult_ovf | w_diff_sat;
        o_msu       = w_diff_sat ? (w_diff[32] ? MIN_32 : MAX_32) : w_diff[31:0];

        // Shift fits only if every bit above bit 31 still matches the sign
        w_shl_wide  = 48'(i_acc) <<< SHIFT;
        o_shl_ovf   = (w_shl_wide[47:31] != {17{i_acc[31]}});
        o_shl       = o_shl_ovf ? (i_acc[31] ? MIN_32 : MAX_32) : w_shl_wide[31:0];

        // Adding 0x8000 carries into the upper half exactly when bit 15 is set
        w_rsum_hi   = {i_acc[31], i_acc[31:16]} + {16'd0, i_acc[15]};
        o_round_ovf = (w_rsum_hi[16] != w_rsum_hi[15]);
        o_round     = o_round_ovf ? (w_rsum_hi[16] ? MIN_16 : MAX_16) : w_rsum_hi[15:0];
    end

endmodule

// File: rtl/syn_filt_param.sv
// Parametrised G.729-style synthesis filter on the shared scratch memory bus.
// y[n] = round(L_shl(a0*x[n] - sum a[i]*y[n-i], SHIFT)), history kept in scratch.
module syn_filt_param
    import syn_filt_param_pkg::*;
#(
    parameter int ORDER     = 10,
    parameter int LEN       = 40,
    parameter int SHIFT     = 3,
    parameter int TEMP_BASE = SYN_FILT_TEMP,
    parameter int AW        = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          update,
    input  logic [AW-1:0] xAddr,
    input  logic [AW-1:0] aAddr,
    input  logic [AW-1:0] yAddr,
    input  logic [AW-1:0] fMemAddr,
    input  logic [31:0]   memIn,
    output logic [AW-1:0] memReadAddr,
    output logic [AW-1:0] memWriteAddr,
    output logic          memWriteEn,
    output logic [31:0]   memOut,
    output logic          done,
    output logic          overflow,
    output logic          busy
);

    localparam int            CW       = 6;
    localparam logic [CW-1:0] ORD_LAST = CW'(ORDER - 1);
    localparam logic [CW-1:0] ORD_CNT  = CW'(ORDER);
    localparam logic [CW-1:0] LEN_LAST = CW'(LEN - 1);
    localparam logic [AW-1:0] TEMP_A   = AW'(TEMP_BASE);
    localparam logic [AW-1:0] Y_SCR    = AW'(TEMP_BASE + ORDER);

    state_t             r_state;
    logic [CW-1:0]      r_k, r_n, r_i;
    logic               r_ph, r_upd, r_done, r_ovf, r_busy;
    logic signed [15:0] r_x, r_a;
    logic signed [31:0] r_acc;

    logic signed [15:0] w_din, w_op_a, w_round;
    logic signed [31:0] w_mult, w_msu, w_shl;
    logic               w_mult_ovf, w_msu_ovf, w_shl_ovf, w_round_ovf;
    logic [AW-1:0]      w_y_rd, w_upd_base;
    logic               w_unused_hi;

    // Only the low half of the read word carries the Q15 sample
    assign w_din       = memIn[15:0];
    assign w_unused_hi = ^memIn[31:16];
    assign w_op_a      = (r_state == S_MSU) ? r_a : r_x;
    assign w_y_rd      = Y_SCR + AW'(r_n) - AW'(r_i);

    // Short subframes keep part of the old history, so it is taken from scratch
    generate
        if (LEN >= ORDER) begin : g_upd_from_y
            assign w_upd_base = yAddr + AW'(LEN - ORDER);
        end else begin : g_upd_from_scratch
            assign w_upd_base = AW'(TEMP_BASE + LEN);
        end
    endgenerate

    basic_op_sat #(.SHIFT(SHIFT)) u_ops (
        .i_acc      (r_acc),
        .i_a        (w_op_a),
        .i_b        (w_din),
        .o_mult     (w_mult),
        .o_mult_ovf (w_mult_ovf),
        .o_msu      (w_msu),
        .o_msu_ovf  (w_msu_ovf),
        .o_shl      (w_shl),
        .o_shl_ovf  (w_shl_ovf),
        .o_round    (w_round),
        .o_round_ovf(w_round_ovf)
    );

    // Sequencer: load history, per-sample MAC loop, copy out, optional update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_n     <= '0;
            r_i     <= '0;
            r_ph    <= 1'b0;
            r_upd   <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_x     <= '0;
            r_a     <= '0;
            r_acc   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_upd   <= update;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_k     <= '0;
                        r_n     <= '0;
                        r_ph    <= 1'b0;
                        r_state <= S_LOADM;
                    end
                end
                S_LOADM: begin
                    r_ph <= ~r_ph;
                    if (r_ph) begin
                        if (r_k == ORD_LAST) begin
                            r_k     <= '0;
                            r_state <= S_RDX;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                S_RDX:  r_state <= S_RDA0;
                S_RDA0: begin
                    r_x     <= w_din;
                    r_state <= S_MAC0;
                end
                S_MAC0: begin
                    r_acc   <= w_mult;
                    r_ovf   <= r_ovf | w_mult_ovf;
                    r_i     <= CW'(1);
                    r_state <= S_RDAI;
                end
                S_RDAI: r_state <= S_RDY;
                S_RDY: begin
                    r_a     <= w_din;
                    r_state <= S_MSU;
                end
                S_MSU: begin
                    r_acc <= w_msu;
                    r_ovf <= r_ovf | w_msu_ovf;
                    if (r_i == ORD_CNT) begin
                        r_state <= S_SHR;
                    end else begin
                        r_i     <= r_i + 1'b1;
                        r_state <= S_RDAI;
                    end
                end
                S_SHR: begin
                    r_acc   <= w_shl;
                    r_ovf   <= r_ovf | w_shl_ovf;
                    r_state <= S_WRT;
                end
                S_WRT: begin
                    r_ovf <= r_ovf | w_round_ovf;
                    if (r_n == LEN_LAST) begin
                        r_n     <= '0;
                        r_k     <= '0;
                        r_ph    <= 1'b0;
                        r_state <= S_COPY;
                    end else begin
                        r_n     <= r_n + 1'b1;
                        r_state <= S_RDX;
                    end
                end
                S_COPY: begin
                    r_ph <= ~r_ph;
                    if (r_ph) begin
                        if (r_k == LEN_LAST) begin
                            r_k     <= '0;
                            r_state <= r_upd ? S_UPD : S_FIN;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                S_UPD: begin
                    r_ph <= ~r_ph;
                    if (r_ph) begin
                        if (r_k == ORD_LAST) begin
                            r_k     <= '0;
                            r_state <= S_FIN;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus decode from registered state/counters; write data, address, enable move together
    always_comb begin
        memReadAddr  = '0;
        memWriteAddr = '0;
        memWriteEn   = 1'b0;
        memOut       = '0;
        case (r_state)
            S_LOADM: begin
                if (!r_ph) begin
                    memReadAddr = fMemAddr + AW'(r_k);
                end else begin
                    memWriteEn   = 1'b1;
                    memWriteAddr = TEMP_A + AW'(r_k);
                    memOut       = sext16(w_din);
                end
            end
            S_RDX:  memReadAddr = xAddr + AW'(r_n);
            S_RDA0: memReadAddr = aAddr;
            S_RDAI: memReadAddr = aAddr + AW'(r_i);
            S_RDY:  memReadAddr = w_y_rd;
            S_WRT: begin
                memWriteEn   = 1'b1;
                memWriteAddr = Y_SCR + AW'(r_n);
                memOut       = sext16(w_round);
            end
            S_COPY: begin
                if (!r_ph) begin
                    memReadAddr = Y_SCR + AW'(r_k);
                end else begin
                    memWriteEn   = 1'b1;
                    memWriteAddr = yAddr + AW'(r_k);
                    memOut       = sext16(w_din);
                end
            end
            S_UPD: begin
                if (!r_ph) begin
                    memReadAddr = w_upd_base + AW'(r_k);
                end else begin
                    memWriteEn   = 1'b1;
                    memWriteAddr = fMemAddr + AW'(r_k);
                    memOut       = sext16(w_din);
                end
            end
            default: ;
        endcase
    end

    assign done     = r_done;
    assign overflow = r_ovf;
    assign busy     = r_busy;

endmodule

// File: tb/tb_syn_filt_param.sv
// Directed bench for syn_filt_param: default instance (ORDER=10, LEN=40) and a
// small instance (ORDER=4, LEN=3) whose scratch area wraps past 2^AW.
module tb_syn_filt_param;
    import syn_filt_param_pkg::*;

    localparam int AW = 11;
    localparam int X1 = 'h000, A1 = 'h040, Y1 = 'h080, F1 = 'h100;
    localparam int X2 = 'h200, A2 = 'h210, Y2 = 'h220, F2 = 'h230;
    localparam int T1 = SYN_FILT_TEMP;
    localparam int T2 = 2046;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start1, update1, start2, update2;
    logic [AW-1:0] rd1, wa1, rd2, wa2;
    logic          we1, we2, done1, done2, ovf1, ovf2, busy1, busy2;
    logic [31:0]   wd1, wd2, rdata1, rdata2;

    logic [31:0]   mem1 [0:2047];
    logic [31:0]   mem2 [0:2047];
    logic          tb_we1, tb_we2;
    logic [AW-1:0] tb_wa;
    logic [31:0]   tb_wd;

    int checks   = 0;
    int failures = 0;

    syn_filt_param dut1 (
        .clk(clk), .reset(reset), .start(start1), .update(update1),
        .xAddr(AW'(X1)), .aAddr(AW'(A1)), .yAddr(AW'(Y1)), .fMemAddr(AW'(F1)),
        .memIn(rdata1), .memReadAddr(rd1), .memWriteAddr(wa1), .memWriteEn(we1),
        .memOut(wd1), .done(done1), .overflow(ovf1), .busy(busy1)
    );

    syn_filt_param #(.ORDER(4), .LEN(3), .SHIFT(3), .TEMP_BASE(T2), .AW(AW)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .update(update2),
        .xAddr(AW'(X2)), .aAddr(AW'(A2)), .yAddr(AW'(Y2)), .fMemAddr(AW'(F2)),
        .memIn(rdata2), .memReadAddr(rd2), .memWriteAddr(wa2), .memWriteEn(we2),
        .memOut(wd2), .done(done2), .overflow(ovf2), .busy(busy2)
    );

    // Scratch memories with registered read and a bench-side load port
    always @(posedge clk) begin
        rdata1 <= mem1[rd1];
        if (we1) mem1[wa1] <= wd1;
        else if (tb_we1) mem1[tb_wa] <= tb_wd;
        rdata2 <= mem2[rd2];
        if (we2) mem2[wa2] <= wd2;
        else if (tb_we2) mem2[tb_wa] <= tb_wd;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Upper half is junk so the design must ignore memIn[31:16]
    function automatic logic [31:0] q15w(input int v);
        logic [15:0] lo;
        lo = 16'(v);
        return {16'hA5A5, lo};
    endfunction

    task automatic wr(input logic sel, input int addr, input logic [31:0] data);
        @(negedge clk);
        tb_wa  = AW'(addr);
        tb_wd  = data;
        tb_we1 = !sel;
        tb_we2 = sel;
        @(posedge clk);
        #1;
        tb_we1 = 1'b0;
        tb_we2 = 1'b0;
    endtask

    task automatic load1(input int a0, input int a1, input int fm, input int x0);
        for (int k = 0; k <= 10; k++) wr(1'b0, A1 + k, q15w(k == 0 ? a0 : (k == 1 ? a1 : 0)));
        for (int k = 0; k < 10; k++) wr(1'b0, F1 + k, q15w(fm));
        for (int n = 0; n < 40; n++) wr(1'b0, X1 + n, q15w(n == 0 ? x0 : 0));
    endtask

    // One filter run on dut1; update input is flipped after start to prove it is latched
    task automatic run1(input string tag, input logic upd, input int extra_at, input int exp_cyc);
        int cyc;
        int extra_done;
        @(negedge clk);
        start1  = 1'b1;
        update1 = upd;
        cyc     = 0;
        while (1) begin
            @(posedge clk);
            cyc++;
            #1;
            start1 = (cyc == extra_at);
            if (cyc == 1) update1 = !upd;
            if (cyc == 2) check_val({tag, "_busy"}, 32'(busy1), 32'd1);
            if (done1 || cyc >= 5000) break;
        end
        start1 = 1'b0;
        check_val({tag, "_done"}, 32'(done1), 32'd1);
        check_val({tag, "_cycles"}, cyc, exp_cyc);
        extra_done = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done1) extra_done++;
        end
        check_val({tag, "_single_done"}, extra_done, 0);
        check_val({tag, "_idle"}, 32'(busy1), 32'd0);
        $display("run %s: cycles=%0d overflow=%0b", tag, cyc, ovf1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset = 1'b1;
        start1 = 1'b0; update1 = 1'b0; start2 = 1'b0; update2 = 1'b0;
        tb_we1 = 1'b0; tb_we2 = 1'b0; tb_wa = '0; tb_wd = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(busy1), 0);
        check_val("rst_done", 32'(done1), 0);
        check_val("rst_we", 32'(we1), 0);
        check_val("rst_ovf", 32'(ovf1), 0);
        check_val("rst_raddr", 32'(rd1), 0);
        @(negedge clk);
        reset = 1'b0;

        // Saturation: a0=x0=32767 saturates L_shl and round
        load1(32767, 0, 0, 32767);
        run1("sat", 1'b0, 0, 1502);
        check_val("sat_y0", mem1[Y1], 32'd32767);
        check_val("sat_y1", mem1[Y1 + 1], 32'd0);
        check_val("sat_ovf", 32'(ovf1), 32'd1);

        // Identity gain: a0=4096 -> y==x; spurious start mid-run ignored
        for (int n = 0; n < 40; n++) begin
            int xv;
            xv = (n == 0) ? 1000 : (n == 1) ? -2000 : (n == 2) ? int'(MAX_16) :
                 (n == 3) ? int'(MIN_16) : n * 811 - 16000;
            wr(1'b0, X1 + n, q15w(xv));
        end
        for (int k = 0; k < 10; k++) wr(1'b0, F1 + k, q15w(0));
        for (int k = 0; k <= 10; k++) wr(1'b0, A1 + k, q15w(k == 0 ? 4096 : 0));
        run1("ident", 1'b0, 200, 1502);
        check_val("ident_ovf_cleared", 32'(ovf1), 32'd0);
        check_val("ident_y0", mem1[Y1], 32'd1000);
        check_val("ident_y1", mem1[Y1 + 1], 32'hFFFF_F830);
        check_val("ident_y2", mem1[Y1 + 2], 32'h0000_7FFF);
        check_val("ident_y3", mem1[Y1 + 3], 32'hFFFF_8000);
        for (int n = 4; n < 40; n++) check_val($sformatf("ident_y%0d", n), mem1[Y1 + n], n * 811 - 16000);
        check_val("ident_fmem0_kept", mem1[F1], q15w(0));
        check_val("ident_fmem9_kept", mem1[F1 + 9], q15w(0));

        // One-pole decay from an impulse, with filter-memory update
        load1(4096, -2048, 0, 1000);
        run1("decay", 1'b1, 0, 1522);
        check_val("decay_y0", mem1[Y1], 32'd1000);
        check_val("decay_y1", mem1[Y1 + 1], 32'd500);
        check_val("decay_y2", mem1[Y1 + 2], 32'd250);
        check_val("decay_y3", mem1[Y1 + 3], 32'd125);
        check_val("decay_y4", mem1[Y1 + 4], 32'd63);
        check_val("decay_y39", mem1[Y1 + 39], 32'd1);
        check_val("decay_fmem0", mem1[F1], 32'd1);
        check_val("decay_fmem9", mem1[F1 + 9], 32'd1);
        check_val("decay_ovf", 32'(ovf1), 32'd0);

        // Nonzero history mem=100 with zero input
        load1(4096, -2048, 100, 0);
        run1("hist", 1'b1, 0, 1522);
        check_val("hist_y0", mem1[Y1], 32'd50);
        check_val("hist_y1", mem1[Y1 + 1], 32'd25);
        check_val("hist_y2", mem1[Y1 + 2], 32'd13);
        check_val("hist_y3", mem1[Y1 + 3], 32'd7);
        check_val("hist_y4", mem1[Y1 + 4], 32'd4);
        check_val("hist_y5", mem1[Y1 + 5], 32'd2);
        check_val("hist_fmem0", mem1[F1], 32'd1);
        check_val("hist_scratch_m9", mem1[T1 + 9], 32'd100);

        // Asynchronous reset in the MAC loop of sample 1 (RDY state)
        load1(32767, 0, 0, 32767);
        @(negedge clk);
        start1 = 1'b1;
        update1 = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            start1 = 1'b0;
        end
        #1;
        check_val("mid_busy", 32'(busy1), 32'd1);
        check_val("mid_raddr", 32'(rd1), T1 + 10);
        reset = 1'b1;
        #1;
        check_val("arst_raddr", 32'(rd1), 0);
        check_val("arst_waddr", 32'(wa1), 0);
        check_val("arst_we", 32'(we1), 0);
        check_val("arst_wdata", wd1, 0);
        check_val("arst_busy", 32'(busy1), 0);
        check_val("arst_done", 32'(done1), 0);
        check_val("arst_ovf", 32'(ovf1), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("arst_we_after", 32'(we1), 0);
        load1(4096, -2048, 0, 1000);
        run1("after_rst", 1'b0, 0, 1502);
        check_val("after_rst_y0", mem1[Y1], 32'd1000);
        check_val("after_rst_y1", mem1[Y1 + 1], 32'd500);
        check_val("after_rst_y4", mem1[Y1 + 4], 32'd63);

        // Small instance: LEN<ORDER history update, scratch wraps past 2047
        for (int k = 0; k <= 4; k++) wr(1'b1, A2 + k, q15w(k == 0 ? 4096 : (k == 1 ? -2048 : 0)));
        for (int k = 0; k < 4; k++) wr(1'b1, F2 + k, q15w(10 * (k + 1)));
        for (int n = 0; n < 3; n++) wr(1'b1, X2 + n, q15w(0));
        @(negedge clk);
        start2  = 1'b1;
        update2 = 1'b1;
        cyc = 0;
        while (1) begin
            @(posedge clk);
            cyc++;
            #1;
            start2 = 1'b0;
            if (done2 || cyc >= 1000) break;
        end
        check_val("wrap_done", 32'(done2), 32'd1);
        check_val("wrap_cycles", cyc, 75);
        $display("run wrap: cycles=%0d overflow=%0b", cyc, ovf2);
        check_val("wrap_y0", mem2[Y2], 32'd20);
        check_val("wrap_y1", mem2[Y2 + 1], 32'd10);
        check_val("wrap_y2", mem2[Y2 + 2], 32'd5);
        check_val("wrap_fmem0", mem2[F2], 32'd40);
        check_val("wrap_fmem1", mem2[F2 + 1], 32'd20);
        check_val("wrap_fmem2", mem2[F2 + 2], 32'd10);
        check_val("wrap_fmem3", mem2[F2 + 3], 32'd5);
        check_val("wrap_scratch_lo", mem2[2046], 32'd10);
        check_val("wrap_scratch_hi", mem2[4], 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
